reg_xchg_seq: RTL and testbench

//  Sequences Z80 register-exchange ops (EX DE,HL / EX AF,AF' / EXX) onto the register file's 2 read + 1 write ports.

---
 rtl/reg_xchg_seq_pkg.sv | 22 ++
 rtl/reg_xchg_seq_pair_rom.sv | 19 +
 rtl/reg_xchg_seq.sv | 87 ++++++++
 tb/tb_reg_xchg_seq.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/reg_xchg_seq_pkg.sv
// reg_xchg_seq_pkg: register select codes, exchange op codes and sequencer state encoding
package reg_xchg_seq_pkg;
  typedef logic [4:0] reg_sel_t;
  localparam reg_sel_t REG_BC  = 5'd0;
  localparam reg_sel_t REG_DE  = 5'd1;
  localparam reg_sel_t REG_HL  = 5'd2;
  localparam reg_sel_t REG_AF  = 5'd3;
  localparam reg_sel_t REG_BC2 = 5'd4;
  localparam reg_sel_t REG_DE2 = 5'd5;
  localparam reg_sel_t REG_HL2 = 5'd6;
  localparam reg_sel_t REG_AF2 = 5'd7;
  typedef logic [1:0] xchg_op_t;
  localparam xchg_op_t XCHG_OP_EXDEHL = 2'd0;
  localparam xchg_op_t XCHG_OP_EXAF   = 2'd1;
  localparam xchg_op_t XCHG_OP_EXX    = 2'd2;
  localparam xchg_op_t XCHG_OP_RSVD   = 2'd3;
  typedef logic [1:0] xchg_state_t;
  localparam xchg_state_t ST_IDLE   = 2'd0;
  localparam xchg_state_t ST_SWAP_A = 2'd1;
  localparam xchg_state_t ST_SWAP_B = 2'd2;
  localparam xchg_state_t ST_DONE   = 2'd3;
endpackage

// File: rtl/reg_xchg_seq_pair_rom.sv
// reg_xchg_pair_rom: maps (op, pair index) to the two register selects being swapped
import reg_xchg_seq_pkg::*;
module reg_xchg_pair_rom #(
  parameter int SEL_W = 5
) (
  input  logic [1:0]       op,
  input  logic [1:0]       idx,
  output logic [SEL_W-1:0] x,
  output logic [SEL_W-1:0] y
);
  reg_sel_t xs, ys;
  // EXX walks BC, DE, HL against their primes; other ops have a single pair
  always_comb begin
    xs = op == XCHG_OP_EXAF ? REG_AF : op == XCHG_OP_EXX ? (idx == 2'd0 ? REG_BC : idx == 2'd1 ? REG_DE : REG_HL) : REG_DE;
    ys = op == XCHG_OP_EXAF ? REG_AF2 : op == XCHG_OP_EXX ? (idx == 2'd0 ? REG_BC2 : idx == 2'd1 ? REG_DE2 : REG_HL2) : REG_HL;
  end
  assign x = SEL_W'(xs);
  assign y = SEL_W'(ys);
endmodule

// File: rtl/reg_xchg_seq.sv
// reg_xchg_seq: sequences EX DE,HL / EX AF,AF' / EXX onto a 2R1W register file (option: REG_XCHG_FLAG_GUARD_EN)
import reg_xchg_seq_pkg::*;
module reg_xchg_seq #(
  parameter int SEL_W      = 5,
  parameter bit B2B_ACCEPT = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [1:0]       req_op,
  output logic             req_ready,
  output logic             busy,
  output logic             done,
  input  logic [SEL_W-1:0] core_src1,
  input  logic [SEL_W-1:0] core_src2,
  input  logic             core_wr_en,
  input  logic [SEL_W-1:0] core_dest,
  input  logic [15:0]      core_wdata,
  input  logic             core_f_wr,
  output logic             core_stall,
  output logic [SEL_W-1:0] rf_src1,
  output logic [SEL_W-1:0] rf_src2,
  input  logic [15:0]      rf_out1,
  input  logic [15:0]      rf_out2,
  output logic             rf_write_en,
  output logic [SEL_W-1:0] rf_dest,
  output logic [15:0]      rf_in,
  output logic             rf_f_wr
);
  xchg_state_t state, state_d;
  logic [1:0] op_q, pair_idx;
  logic [15:0] hold;
  logic [SEL_W-1:0] x, y;
  logic accept, last, swap_a, swap_b;

  reg_xchg_pair_rom #(.SEL_W(SEL_W)) u_rom (.op(op_q), .idx(pair_idx), .x(x), .y(y));

  assign swap_a = state == ST_SWAP_A;
  assign swap_b = state == ST_SWAP_B;
  assign busy = swap_a || swap_b;
  assign done = state == ST_DONE;
  assign req_ready = state == ST_IDLE || (B2B_ACCEPT && done);
  assign accept = req_valid && req_ready;
  assign last = pair_idx == (op_q == XCHG_OP_EXX ? 2'd2 : 2'd0);
  assign core_stall = busy && (core_wr_en || core_f_wr);

  // next state: reserved op skips straight to DONE with no writes
  always_comb begin
    state_d = swap_a ? ST_SWAP_B : swap_b ? (last ? ST_DONE : ST_SWAP_A) : accept ? (req_op == XCHG_OP_RSVD ? ST_DONE : ST_SWAP_A) : ST_IDLE;
  end

  // port muxes: the sequencer owns the register file while busy, core passes through otherwise
  always_comb begin
    rf_src1 = busy ? x : core_src1;
    rf_src2 = busy ? y : core_src2;
    rf_write_en = busy || core_wr_en;
    rf_dest = swap_a ? x : swap_b ? y : core_dest;
    rf_in = swap_a ? rf_out2 : swap_b ? hold : core_wdata;
  end

`ifdef REG_XCHG_FLAG_GUARD_EN
  assign rf_f_wr = core_f_wr && !busy && !(state == ST_IDLE && accept && req_op == XCHG_OP_EXAF);
`else
  assign rf_f_wr = core_f_wr;
`ifdef FORMAL
  // the core must keep f_wr low while the sequencer owns the ports
  always @(posedge clk) if (!reset && busy) assert (!core_f_wr);
`endif
`endif

  // FSM, op latch, pair counter and the 16-bit holding latch for the second write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      op_q <= '0;
      pair_idx <= '0;
      hold <= '0;
    end else begin
      state <= state_d;
      if (accept) begin
        op_q <= req_op;
        pair_idx <= '0;
      end else if (swap_b && !last) pair_idx <= pair_idx + 2'd1;
      if (swap_a) hold <= rf_out1;
    end
  end
endmodule

// File: tb/tb_reg_xchg_seq.sv
// tb_reg_xchg_seq: scoreboard bench for reg_xchg_seq with a behavioural 2R1W register file
import reg_xchg_seq_pkg::*;
module tb_reg_xchg_seq;
  typedef logic [7:0][15:0] regs_t;
  typedef struct { int lat; int wr; regs_t r; } exp_t;

  logic clk = 0, reset = 1;
  logic req_valid = 0;
  logic [1:0] req_op = 0;
  logic req_ready, busy, done, core_stall;
  logic [4:0] core_src1 = 0, core_src2 = 0, core_dest = 0;
  logic core_wr_en = 0, core_f_wr = 0;
  logic [15:0] core_wdata = 0;
  logic [4:0] rf_src1, rf_src2, rf_dest;
  logic [15:0] rf_out1, rf_out2, rf_in;
  logic rf_write_en, rf_f_wr;
  logic [7:0] f_in = 0;
  regs_t rf, pl_val, m;
  logic pl_en = 0;
  int cyc = 0, n_tests = 0, n_fail = 0, wcnt = 0;
  exp_t exp_q[$];
  int acc_q[$];

  reg_xchg_seq dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op), .req_ready(req_ready),
    .busy(busy), .done(done), .core_src1(core_src1), .core_src2(core_src2), .core_wr_en(core_wr_en),
    .core_dest(core_dest), .core_wdata(core_wdata), .core_f_wr(core_f_wr), .core_stall(core_stall),
    .rf_src1(rf_src1), .rf_src2(rf_src2), .rf_out1(rf_out1), .rf_out2(rf_out2),
    .rf_write_en(rf_write_en), .rf_dest(rf_dest), .rf_in(rf_in), .rf_f_wr(rf_f_wr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign rf_out1 = rf[rf_src1[2:0]];
  assign rf_out2 = rf[rf_src2[2:0]];
  // register file: a full AF write takes priority over the flag-only write
  always @(posedge clk) begin
    if (pl_en) rf <= pl_val;
    else begin
      if (rf_f_wr) rf[int'(REG_AF)][7:0] <= f_in;
      if (rf_write_en) rf[rf_dest[2:0]] <= rf_in;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor: counts sequencer writes and scores every done pulse against the queue head
  task automatic monitor();
    exp_t e;
    int a;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_q.delete();
        acc_q.delete();
        wcnt = 0;
      end else begin
        if (busy) begin
          wcnt += int'(rf_write_en);
          chk("stall", core_stall, core_wr_en || core_f_wr);
        end
        if (done) begin
          if (exp_q.size() == 0 || acc_q.size() == 0) chk("spurious_done", 1, 0);
          else begin
            e = exp_q.pop_front();
            a = acc_q.pop_front();
            chk("latency", cyc - a, e.lat);
            chk("writes", wcnt, e.wr);
            for (int i = 0; i < 8; i++) chk($sformatf("reg%0d", i), rf[i], e.r[i]);
          end
          wcnt = 0;
        end
        if (req_valid && req_ready) acc_q.push_back(cyc);
      end
    end
  endtask

  task automatic preload(input regs_t v);
    pl_val = v;
    pl_en = 1;
    @(posedge clk); #1;
    pl_en = 0;
  endtask

  task automatic issue(input logic [1:0] op, input int lat, input int wr, input regs_t r);
    exp_q.push_back('{lat, wr, r});
    req_valid = 1;
    req_op = op;
    @(posedge clk); #1;
    req_valid = 0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    chk("timeout", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    fork monitor(); join_none
    core_wr_en = 1; core_dest = REG_HL; core_wdata = 16'habcd;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_stall", core_stall, 0);
    chk("rst_wr_pass", rf_write_en, 1);
    chk("rst_dest_pass", rf_dest, REG_HL);
    chk("rst_in_pass", rf_in, 16'habcd);
    @(posedge clk); #1;
    reset = 0; core_wr_en = 0;
    core_src1 = REG_HL; core_src2 = REG_AF; core_dest = REG_BC2; core_wdata = 16'h1357; core_f_wr = 1; f_in = 8'h77;
    @(negedge clk);
    chk("idle_src1", rf_src1, REG_HL);
    chk("idle_src2", rf_src2, REG_AF);
    chk("idle_dest", rf_dest, REG_BC2);
    chk("idle_in", rf_in, 16'h1357);
    chk("idle_wr", rf_write_en, 0);
    chk("idle_fwr", rf_f_wr, 1);
    @(posedge clk); #1;
    core_f_wr = 0;
    // 1: EX DE,HL
    m = '0; m[1] = 16'h1234; m[2] = 16'h5678; preload(m);
    m[1] = 16'h5678; m[2] = 16'h1234; issue(XCHG_OP_EXDEHL, 3, 2, m); wait_idle();
    // 2: EX AF,AF' twice
    m = '0; m[3] = 16'haa55; m[7] = 16'h0f0f; preload(m);
    m[3] = 16'h0f0f; m[7] = 16'haa55; issue(XCHG_OP_EXAF, 3, 2, m); wait_idle();
    m[3] = 16'haa55; m[7] = 16'h0f0f; issue(XCHG_OP_EXAF, 3, 2, m); wait_idle();
    // 3: EXX
    m = '0; m[0] = 16'h1111; m[1] = 16'h2222; m[2] = 16'h3333; m[4] = 16'haaaa; m[5] = 16'hbbbb; m[6] = 16'hcccc; preload(m);
    m[0] = 16'haaaa; m[1] = 16'hbbbb; m[2] = 16'hcccc; m[4] = 16'h1111; m[5] = 16'h2222; m[6] = 16'h3333;
    issue(XCHG_OP_EXX, 7, 6, m); wait_idle();
    // reserved op: done after one cycle, nothing written
    issue(XCHG_OP_RSVD, 1, 0, m); wait_idle();
    // 4: core write in the accept cycle lands first; later core writes are stalled and dropped
    m = '0; m[1] = 16'h1234; m[2] = 16'h5678; preload(m);
    m[1] = 16'h5678; m[2] = 16'h9999;
    exp_q.push_back('{3, 2, m});
    req_valid = 1; req_op = XCHG_OP_EXDEHL; core_wr_en = 1; core_dest = REG_DE; core_wdata = 16'h9999;
    @(posedge clk); #1;
    req_valid = 0; core_dest = REG_BC; core_wdata = 16'hdead;
    @(negedge clk);
    chk("busy_stall", core_stall, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    core_wr_en = 0;
    wait_idle();
    // 5: reset in SWAP_B of EXX abandons the swap
    m = '0; m[0] = 16'h1111; m[1] = 16'h2222; m[2] = 16'h3333; m[4] = 16'haaaa; m[5] = 16'hbbbb; m[6] = 16'hcccc; preload(m);
    exp_q.push_back('{7, 6, m});
    req_valid = 1; req_op = XCHG_OP_EXX;
    @(posedge clk); #1;
    req_valid = 0;
    @(posedge clk); #1;
    chk("pre_rst_busy", busy, 1);
    reset = 1;
    @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_ready", req_ready, 1);
    @(posedge clk); #1;
    reset = 0;
    m = '0; m[0] = 16'haaaa; m[1] = 16'h3333; m[2] = 16'h2222; m[4] = 16'haaaa; m[5] = 16'hbbbb; m[6] = 16'hcccc;
    issue(XCHG_OP_EXDEHL, 3, 2, m); wait_idle();
    // 6: back-to-back EX DE,HL accepted in DONE
    m = '0; m[1] = 16'h1234; m[2] = 16'h5678; preload(m);
    m[1] = 16'h5678; m[2] = 16'h1234; exp_q.push_back('{3, 2, m});
    m[1] = 16'h1234; m[2] = 16'h5678; exp_q.push_back('{3, 2, m});
    req_valid = 1; req_op = XCHG_OP_EXDEHL;
    @(posedge clk); #1;
    req_valid = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    req_valid = 1;
    @(negedge clk);
    chk("b2b_ready", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 0;
    @(negedge clk);
    chk("b2b_busy", busy, 1);
    wait_idle();
`ifdef REG_XCHG_FLAG_GUARD_EN
    // flag writes are dropped from the accept cycle through the swap
    m = '0; m[3] = 16'haa55; m[7] = 16'h0f0f; preload(m);
    m[3] = 16'h0f0f; m[7] = 16'haa55; exp_q.push_back('{3, 2, m});
    req_valid = 1; req_op = XCHG_OP_EXAF; core_f_wr = 1; f_in = 8'hff;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("guard_fwr%0d", i), rf_f_wr, 0);
      @(posedge clk); #1;
      req_valid = 0;
    end
    core_f_wr = 0;
    wait_idle();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
